// File: rtl/pixel_replicator_if.sv
// Pixel stream bundle around the replicator: a valid/ready source side and a
// valid-only sink side.
// Handshake: a source pixel transfers on a rising clk edge where s_valid and
// s_ready are both 1; the source holds s_pixel/s_valid stable until then.
// The sink side has no ready and must take every cycle where m_valid is 1.
interface pixel_replicator_if;
   logic [23:0] s_pixel;
   logic        s_valid;
   logic        s_ready;
   logic [23:0] m_pixel;
   logic        m_valid;

   // Environment view: feeds source pixels and observes the replicated stream.
   modport master (
      output s_pixel, s_valid,
      input  s_ready, m_pixel, m_valid
   );

   // Replicator view.
   modport slave (
      input  s_pixel, s_valid,
      output s_ready, m_pixel, m_valid
   );
endinterface

// File: rtl/pixel_replicator.sv
// Nearest-neighbour replicator: buffers one source row, then replays it SCALE
// times with each pixel held for SCALE valid cycles and one idle cycle after
// every pass. Output runs two cycles behind the state register (buffer read
// stage + output register).
module pixel_replicator #(
   parameter int IMG_W = 384,
   parameter int IMG_H = 216,
   parameter int SCALE = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   pixel_replicator_if.slave   bus,
   output logic                frame_done,
   output logic [1:0]          dbg_state
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(SCALE - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_EMIT = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t             state, state_n;
   logic [COL_W-1:0]   col;
   logic [REP_W-1:0]   rep;
   logic [REP_W-1:0]   pass;
   logic [ROW_W-1:0]   row_cnt;
   logic [23:0]        row_buf [IMG_W];
   logic [23:0]        rd_q;
   logic               emit_q;
   logic               fd_q;
   logic               s_ready_int;
   logic               hs;

   assign s_ready_int = (state == ST_FILL);
   assign bus.s_ready = s_ready_int;
   assign hs          = bus.s_valid && s_ready_int;
   assign dbg_state   = state;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   // Next-state decode: fill a row, emit it pass by pass with a gap after each.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: state_n = ST_FILL;
         ST_FILL: if (hs && col == COL_LAST) state_n = ST_EMIT;
         ST_EMIT: if (rep == REP_LAST && col == COL_LAST) state_n = ST_GAP;
         ST_GAP:  state_n = (pass == REP_LAST) ? ST_FILL : ST_EMIT;
         default: state_n = ST_IDLE;
      endcase
   end

   // Column, repeat, pass and row counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col     <= '0;
         rep     <= '0;
         pass    <= '0;
         row_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               col  <= '0;
               rep  <= '0;
               pass <= '0;
            end
            ST_FILL: begin
               if (hs) begin
                  if (col == COL_LAST) begin
                     col  <= '0;
                     rep  <= '0;
                     pass <= '0;
                  end else begin
                     col <= col + COL_W'(1);
                  end
               end
            end
            ST_EMIT: begin
               if (rep == REP_LAST) begin
                  rep <= '0;
                  col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
               end else begin
                  rep <= rep + REP_W'(1);
               end
            end
            ST_GAP: begin
               if (pass == REP_LAST) begin
                  pass    <= '0;
                  row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_W'(1);
               end else begin
                  pass <= pass + REP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Row buffer: written on source handshakes, read synchronously while emitting.
   always_ff @(posedge clk) begin
      if (hs) row_buf[col] <= bus.s_pixel;
      if (state == ST_EMIT) rd_q <= row_buf[col];
   end

   // Output pipeline: delays valid and frame-end marker to line up with read data;
   // m_pixel holds its last value through gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         emit_q      <= 1'b0;
         fd_q        <= 1'b0;
         bus.m_valid <= 1'b0;
         bus.m_pixel <= '0;
         frame_done  <= 1'b0;
      end else begin
         emit_q      <= (state == ST_EMIT);
         fd_q        <= (state == ST_GAP) && (pass == REP_LAST) && (row_cnt == ROW_LAST);
         bus.m_valid <= emit_q;
         frame_done  <= fd_q;
         if (emit_q) bus.m_pixel <= rd_q;
      end
   end

endmodule

// File: tb/tb_pixel_replicator.sv
// Bench for pixel_replicator: a SCALE=3 instance and a SCALE=1 instance,
// both with IMG_W=4, IMG_H=2, sharing clock and reset.
module tb_pixel_replicator;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int S0 = 3;
   localparam int S1 = 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;

   // Clock / reset.
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   pixel_replicator_if u_if0 ();
   pixel_replicator_if u_if1 ();

   logic       fd0, fd1;
   logic [1:0] st0, st1;

   pixel_replicator #(.IMG_W(W), .IMG_H(H), .SCALE(S0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(u_if0), .frame_done(fd0), .dbg_state(st0)
   );

   pixel_replicator #(.IMG_W(W), .IMG_H(H), .SCALE(S1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(u_if1), .frame_done(fd1), .dbg_state(st1)
   );

   int checks = 0;
   int failures = 0;
   logic [23:0] exp_q0[$];
   logic [23:0] exp_q1[$];
   int fd_count0 = 0;
   int fd_cyc0 = 0;
   int fd_count1 = 0;
   int hs_first = 0;
   int hs_last = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected replicated stream for one accepted row.
   task automatic push_row(input int sel, input logic [95:0] row);
      int sc;
      sc = (sel == 0) ? S0 : S1;
      for (int p = 0; p < sc; p++)
         for (int i = 0; i < W; i++)
            for (int r = 0; r < sc; r++)
               if (sel == 0) exp_q0.push_back(row[95-24*i -: 24]);
               else          exp_q1.push_back(row[95-24*i -: 24]);
   endtask

   // Drive one row (first pixel in the top bits); optional bubble before each pixel.
   task automatic send_row(input int sel, input logic [95:0] row, input bit bubbles);
      logic [23:0] p;
      bit rdy;
      int guard;
      for (int i = 0; i < W; i++) begin
         p = row[95-24*i -: 24];
         if (bubbles) begin
            if (sel == 0) u_if0.s_valid = 1'b0; else u_if1.s_valid = 1'b0;
            tick;
            check_eq("fill_ready", (sel == 0) ? u_if0.s_ready : u_if1.s_ready, 1);
         end
         if (sel == 0) begin u_if0.s_valid = 1'b1; u_if0.s_pixel = p; end
         else          begin u_if1.s_valid = 1'b1; u_if1.s_pixel = p; end
         guard = 0;
         do begin
            rdy = (sel == 0) ? u_if0.s_ready : u_if1.s_ready;
            tick;
            guard++;
         end while (!rdy && guard < 200);
         if (!rdy) check_eq("hs_timeout", 0, 1);
         if (i == 0) hs_first = cyc;
      end
      hs_last = cyc;
      if (sel == 0) u_if0.s_valid = 1'b0; else u_if1.s_valid = 1'b0;
      push_row(sel, row);
   endtask

   // Reset pulse with asynchronous output checks, then release into IDLE -> FILL.
   task automatic do_reset;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mvalid", u_if0.m_valid, 0);
      check_eq("rst_sready", u_if0.s_ready, 0);
      check_eq("rst_state", st0, ST_IDLE);
      exp_q0.delete();
      exp_q1.delete();
      fd_count0 = 0;
      fd_count1 = 0;
      repeat (2) tick;
      rst_n = 1'b1;
      check_eq("rel_idle", st0, ST_IDLE);
      tick;
      check_eq("rel_fill", st0, ST_FILL);
      check_eq("rel_ready", u_if0.s_ready, 1);
   endtask

   task automatic wait_drain;
      for (int k = 0; k < 300 && (exp_q0.size() != 0 || exp_q1.size() != 0); k++) tick;
      check_eq("drain", exp_q0.size() + exp_q1.size(), 0);
      repeat (3) tick;
   endtask

   // Scoreboard: every valid output cycle pops one expected pixel.
   always @(negedge clk) begin
      if (rst_n && u_if0.m_valid) begin
         if (exp_q0.size() == 0) check_eq("sb0_extra", 1, 0);
         else check_eq("sb0_pix", u_if0.m_pixel, exp_q0.pop_front());
      end
      if (rst_n && u_if1.m_valid) begin
         if (exp_q1.size() == 0) check_eq("sb1_extra", 1, 0);
         else check_eq("sb1_pix", u_if1.m_pixel, exp_q1.pop_front());
      end
      if (rst_n && fd0) begin
         fd_count0++;
         fd_cyc0 = cyc;
         check_eq("fd0_in_gap", u_if0.m_valid, 0);
      end
      if (rst_n && fd1) fd_count1++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      u_if0.s_valid = 1'b0; u_if0.s_pixel = '0;
      u_if1.s_valid = 1'b0; u_if1.s_pixel = '0;
      rst_n = 1'b0;
      repeat (3) tick;
      check_eq("reset_mvalid", u_if0.m_valid, 0);
      check_eq("reset_mpixel", u_if0.m_pixel, 0);
      check_eq("reset_sready", u_if0.s_ready, 0);
      check_eq("reset_fdone", fd0, 0);
      check_eq("reset_state", st0, ST_IDLE);
      check_eq("reset_mvalid1", u_if1.m_valid, 0);
      rst_n = 1'b1;
      check_eq("start_idle", st0, ST_IDLE);
      tick;
      check_eq("start_fill", st0, ST_FILL);

      // 1: back-to-back row, exact valid/gap timing from the last handshake.
      send_row(0, 96'h000001_000002_000003_000004, 1'b0);
      n = hs_last;
      for (int c = -2; c <= 38; c++) begin
         @(negedge clk);
         check_eq("t1_valid", u_if0.m_valid, (c >= 0) && ((c % 13) != 12));
         check_eq("t1_ready", u_if0.s_ready, (cyc >= n + 39));
         check_eq("t1_fdone", fd0, 0);
      end
      tick;
      wait_drain;

      // 2: bubbles between pixels.
      do_reset;
      send_row(0, 96'h000001_000002_000003_000004, 1'b1);
      wait_drain;

      // 3: two rows, frame_done on the final gap of row B, wrap to row 0.
      do_reset;
      send_row(0, 96'hA00001_A00002_A00003_A00004, 1'b0);
      send_row(0, 96'hB00001_B00002_B00003_B00004, 1'b0);
      n = hs_last;
      repeat (41) tick;
      check_eq("t3_fd_count", fd_count0, 1);
      check_eq("t3_fd_cycle", fd_cyc0, n + 40);
      check_eq("t3_fill", st0, ST_FILL);
      check_eq("t3_row0", u_dut0.row_cnt, 0);
      send_row(0, 96'hC00001_C00002_C00003_C00004, 1'b0);
      wait_drain;
      check_eq("t3_fd_once", fd_count0, 1);

      // 4: reset in the middle of pass 2, then a clean row.
      do_reset;
      send_row(0, 96'h110001_110002_110003_110004, 1'b0);
      repeat (20) tick;
      check_eq("t4_pre_valid", u_if0.m_valid, 1);
      do_reset;
      send_row(0, 96'h220001_220002_220003_220004, 1'b0);
      wait_drain;

      // 5: source holds a pixel through EMIT; it is only taken in the next FILL.
      do_reset;
      send_row(0, 96'h330001_330002_330003_330004, 1'b0);
      n = hs_last;
      u_if0.s_valid = 1'b1;
      u_if0.s_pixel = 24'hDEADBE;
      send_row(0, 96'hDEADBE_440002_440003_440004, 1'b0);
      check_eq("t5_hs_cycle", hs_first, n + 40);
      wait_drain;

      // 6: SCALE=1 instance, one pass, one gap, back to FILL.
      send_row(1, 96'h0A0B0C_0D0E0F_101112_131415, 1'b0);
      n = hs_last;
      for (int c = -2; c <= 6; c++) begin
         @(negedge clk);
         check_eq("t6_valid", u_if1.m_valid, (c >= 0) && (c < 4));
         check_eq("t6_ready", u_if1.s_ready, (cyc >= n + 5));
      end
      tick;
      wait_drain;
      check_eq("t6_fd1", fd_count1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
